reg_bus_arbiter: RTL

Two-requester arbiter and sequencer for the 16-entry register bus of the packet-loopback DUT. Accepts read/write requests from two masters (e.g. the config sequencer and the stats/debug port), grants one at a time round-robin, and drives the single-cycle `bus_cmd_valid`/`bus_op`/`bus_addr`/`bus_wr_data` command. It captures `bus_rd_data` one cycle after a read command and returns it to the winning requester. Out-of-range addresses are rejected locally with an error and no bus access.

---
 rtl/reg_bus_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/reg_bus_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the two-port register bus arbiter.
// Both the FSM top and the round-robin picker import this package.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic OP_READ   = 1'b0;
  localparam logic OP_WRITE  = 1'b1;
  localparam int   REG_DEPTH = 16;
  localparam int   NUM_PORTS = 2;

  // Index of the port that was not granted last time.
  function automatic logic other_port(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the port that did not win the previous grant.
module rr_pick2
  import reg_bus_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_idx,
  output logic       any
);

  always_comb begin
    any = |valid;
    unique case (valid)
      2'b11:   grant_idx = other_port(last_grant);
      2'b10:   grant_idx = 1'b1;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two register-bus masters and sequences one single-cycle bus
// command at a time; out-of-range addresses complete locally with an error.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = REG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wr_data,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rd_data,
  input  logic              req1_valid,
  input  logic              req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wr_data,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rd_data,
  output logic              bus_cmd_valid,
  output logic              bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data
);

  // One extra bit so the compare never wraps for any DEPTH up to 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    win_q, win_d;
  logic                    op_q, op_d;
  logic [NUM_PORTS-1:0]    done_q, done_d;
  logic [NUM_PORTS-1:0]    err_q, err_d;
  logic [DATA_W-1:0]       rd_data_q [NUM_PORTS];
  logic [DATA_W-1:0]       rd_data_d [NUM_PORTS];
  logic                    bus_cmd_valid_q, bus_cmd_valid_d;
  logic                    bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]       bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]       bus_wr_data_q, bus_wr_data_d;

  logic                    grant_idx;
  logic                    any_req;
  logic                    sel_op;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wr_data;
  logic                    out_of_range;

  rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  assign sel_op       = grant_idx ? req1_op      : req0_op;
  assign sel_addr     = grant_idx ? req1_addr    : req0_addr;
  assign sel_wr_data  = grant_idx ? req1_wr_data : req0_wr_data;
  assign out_of_range = {1'b0, sel_addr} >= DEPTH_EXT;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    win_d           = win_q;
    op_d            = op_q;
    done_d          = '0;
    err_d           = '0;
    rd_data_d       = rd_data_q;
    bus_cmd_valid_d = 1'b0;
    bus_op_d        = 1'b0;
    bus_addr_d      = '0;
    bus_wr_data_d   = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d        = grant_idx;
          last_grant_d = grant_idx;
          op_d         = sel_op;
          if (out_of_range) begin
            // Rejected locally: complete next cycle without touching the bus.
            state_d           = DONE;
            done_d[grant_idx] = 1'b1;
            err_d[grant_idx]  = 1'b1;
            if (sel_op == OP_READ) begin
              rd_data_d[grant_idx] = '0;
            end
          end else begin
            state_d         = ISSUE;
            bus_cmd_valid_d = 1'b1;
            bus_op_d        = sel_op;
            bus_addr_d      = sel_addr;
            bus_wr_data_d   = sel_wr_data;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_WRITE) begin
          state_d       = DONE;
          done_d[win_q] = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Read data is on the bus the cycle after the command.
        rd_data_d[win_q] = bus_rd_data;
        done_d[win_q]    = 1'b1;
        state_d          = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      win_q           <= 1'b0;
      op_q            <= OP_READ;
      done_q          <= '0;
      err_q           <= '0;
      bus_cmd_valid_q <= 1'b0;
      bus_op_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wr_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      win_q           <= win_d;
      op_q            <= op_d;
      done_q          <= done_d;
      err_q           <= err_d;
      bus_cmd_valid_q <= bus_cmd_valid_d;
      bus_op_q        <= bus_op_d;
      bus_addr_q      <= bus_addr_d;
      bus_wr_data_q   <= bus_wr_data_d;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q[gi] <= '0;
      end else begin
        rd_data_q[gi] <= rd_data_d[gi];
      end
    end
  end

  assign req0_done     = done_q[0];
  assign req1_done     = done_q[1];
  assign req0_err      = err_q[0];
  assign req1_err      = err_q[1];
  assign req0_rd_data  = rd_data_q[0];
  assign req1_rd_data  = rd_data_q[1];
  assign bus_cmd_valid = bus_cmd_valid_q;
  assign bus_op        = bus_op_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wr_data   = bus_wr_data_q;

endmodule
